hubris_run_controller: RTL and testbench

//   Synthesizable run-control and watchdog for Hubris program execution, for FPGA and regression harnesses.

---
 rtl/hubris_run_controller.sv | 130 +++++++++++++
 tb/tb_hubris_run_controller.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hubris_run_controller.sv
// Run-control and watchdog for Hubris cores: reset sequencing, RUN cycle count, per-hart halt capture.
// Optional retired-instruction counter enabled by defining RUN_CTRL_INSTRET_EN.
module hubris_run_controller #(
  parameter int NUM_HARTS    = 1,
  parameter int CNT_WIDTH    = 32,
  parameter int RESET_CYCLES = 4,
  parameter int CYCLE_LIMIT  = 100000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 abort,
  input  logic [NUM_HARTS-1:0] halt_in,
  output logic                 core_reset,
  output logic [1:0]           state,
  output logic [NUM_HARTS-1:0] halted_mask,
  output logic [CNT_WIDTH-1:0] cycle_count,
  output logic                 done,
  output logic                 timeout
`ifdef RUN_CTRL_INSTRET_EN
  ,
  input  logic [NUM_HARTS-1:0] retire_in,
  output logic [CNT_WIDTH-1:0] instret_count
`endif
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RST_HOLD = 2'd1,
    RUN      = 2'd2,
    DONE     = 2'd3
  } state_t;

  localparam int RW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [RW-1:0] RST_LAST = RW'(RESET_CYCLES - 1);

  state_t          st;
  logic [RW-1:0]   rst_cnt;

  function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] a,
                                                   input logic [CNT_WIDTH-1:0] b);
    logic [CNT_WIDTH:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[CNT_WIDTH] ? {CNT_WIDTH{1'b1}} : sum[CNT_WIDTH-1:0];
  endfunction

  logic [CNT_WIDTH-1:0] cnt_inc;
  logic [NUM_HARTS-1:0] mask_nxt;
  logic                 all_halted;
  logic                 limit_hit;

  always_comb begin
    cnt_inc    = sat_add(cycle_count, CNT_WIDTH'(1));
    mask_nxt   = halted_mask | halt_in;
    all_halted = &mask_nxt;
    // Compare in 64 bits so a limit wider than the counter never falsely matches.
    limit_hit  = (CYCLE_LIMIT != 0) && (64'(cnt_inc) == 64'(CYCLE_LIMIT));
  end

`ifdef RUN_CTRL_INSTRET_EN
  logic [CNT_WIDTH-1:0] retire_cnt;
  always_comb retire_cnt = CNT_WIDTH'($countones(retire_in & ~halted_mask));
`endif

  assign state = st;

  always_ff @(posedge clk) begin
    if (reset) begin
      st          <= IDLE;
      core_reset  <= 1'b1;
      halted_mask <= '0;
      cycle_count <= '0;
      done        <= 1'b0;
      timeout     <= 1'b0;
      rst_cnt     <= '0;
`ifdef RUN_CTRL_INSTRET_EN
      instret_count <= '0;
`endif
    end else begin
      case (st)
        IDLE, DONE: begin
          if (start) begin
            st          <= RST_HOLD;
            core_reset  <= 1'b1;
            halted_mask <= '0;
            cycle_count <= '0;
            done        <= 1'b0;
            timeout     <= 1'b0;
            rst_cnt     <= '0;
`ifdef RUN_CTRL_INSTRET_EN
            instret_count <= '0;
`endif
          end
        end
        RST_HOLD: begin
          if (abort) begin
            st <= IDLE;
          end else if (rst_cnt == RST_LAST) begin
            st         <= RUN;
            core_reset <= 1'b0;
          end else begin
            rst_cnt <= rst_cnt + RW'(1);
          end
        end
        RUN: begin
          // The aborting cycle still counts as a RUN cycle.
          cycle_count <= cnt_inc;
          halted_mask <= mask_nxt;
`ifdef RUN_CTRL_INSTRET_EN
          instret_count <= sat_add(instret_count, retire_cnt);
`endif
          if (abort) begin
            st         <= IDLE;
            core_reset <= 1'b1;
          end else if (all_halted) begin
            st      <= DONE;
            done    <= 1'b1;
            timeout <= 1'b0;
          end else if (limit_hit) begin
            st      <= DONE;
            done    <= 1'b1;
            timeout <= 1'b1;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hubris_run_controller.sv
// Directed bench for hubris_run_controller: three instances cover 1/2 harts, timeout, saturation.
module tb_hubris_run_controller;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic       st_a, ab_a, h_a, cr_a, dn_a, to_a;
  logic [1:0] s_a;
  logic       m_a;
  logic [31:0] c_a;

  logic       st_b, ab_b, cr_b, dn_b, to_b;
  logic [1:0] h_b, m_b, s_b;
  logic [31:0] c_b;

  logic       st_c, ab_c, h_c, cr_c, dn_c, to_c, m_c;
  logic [1:0] s_c;
  logic [3:0] c_c;

`ifdef RUN_CTRL_INSTRET_EN
  logic       rt_a, rt_c;
  logic [1:0] rt_b;
  logic [31:0] ic_a, ic_b;
  logic [3:0] ic_c;
`endif

  hubris_run_controller #(.NUM_HARTS(1), .CNT_WIDTH(32), .RESET_CYCLES(4), .CYCLE_LIMIT(50)) u_a (
    .clk(clk), .reset(reset), .start(st_a), .abort(ab_a), .halt_in(h_a),
    .core_reset(cr_a), .state(s_a), .halted_mask(m_a), .cycle_count(c_a),
    .done(dn_a), .timeout(to_a)
`ifdef RUN_CTRL_INSTRET_EN
    , .retire_in(rt_a), .instret_count(ic_a)
`endif
  );

  hubris_run_controller #(.NUM_HARTS(2), .CNT_WIDTH(32), .RESET_CYCLES(4), .CYCLE_LIMIT(20)) u_b (
    .clk(clk), .reset(reset), .start(st_b), .abort(ab_b), .halt_in(h_b),
    .core_reset(cr_b), .state(s_b), .halted_mask(m_b), .cycle_count(c_b),
    .done(dn_b), .timeout(to_b)
`ifdef RUN_CTRL_INSTRET_EN
    , .retire_in(rt_b), .instret_count(ic_b)
`endif
  );

  hubris_run_controller #(.NUM_HARTS(1), .CNT_WIDTH(4), .RESET_CYCLES(1), .CYCLE_LIMIT(0)) u_c (
    .clk(clk), .reset(reset), .start(st_c), .abort(ab_c), .halt_in(h_c),
    .core_reset(cr_c), .state(s_c), .halted_mask(m_c), .cycle_count(c_c),
    .done(dn_c), .timeout(to_c)
`ifdef RUN_CTRL_INSTRET_EN
    , .retire_in(rt_c), .instret_count(ic_c)
`endif
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic go_b();
    st_b = 1'b1;
    step();
    st_b = 1'b0;
    step(4);
  endtask

  initial begin
    reset = 1'b1;
    {st_a, ab_a, h_a, st_b, ab_b, st_c, ab_c, h_c} = '0;
    h_b = '0;
`ifdef RUN_CTRL_INSTRET_EN
    rt_a = 1'b0; rt_b = '0; rt_c = 1'b0;
`endif
    step(2);
    reset = 1'b0;

    chk("rst_state", 64'(s_a), 0);
    chk("rst_core_reset", 64'(cr_a), 1);
    chk("rst_mask", 64'(m_a), 0);
    chk("rst_count", 64'(c_a), 0);
    chk("rst_done", 64'(dn_a), 0);
    chk("rst_timeout", 64'(to_a), 0);

    // 1: reset hold of 4 cycles then RUN
    st_a = 1'b1;
    step();
    st_a = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("hold_state", 64'(s_a), 1);
      chk("hold_core_reset", 64'(cr_a), 1);
      step();
    end
    chk("run_state", 64'(s_a), 2);
    chk("run_core_reset", 64'(cr_a), 0);
    chk("run_first_count", 64'(c_a), 0);

    // 2: halt in the 10th RUN cycle
    step(9);
    chk("pre_halt_count", 64'(c_a), 9);
    h_a = 1'b1;
    step();
    h_a = 1'b0;
    chk("halt_state", 64'(s_a), 3);
    chk("halt_count", 64'(c_a), 10);
    chk("halt_done", 64'(dn_a), 1);
    chk("halt_timeout", 64'(to_a), 0);
    chk("halt_core_reset", 64'(cr_a), 0);
    h_a = 1'b1;
    step(3);
    h_a = 1'b0;
    chk("done_frozen_count", 64'(c_a), 10);
    chk("done_frozen_state", 64'(s_a), 3);

    // 3: restart from DONE, run to cycle limit 50
    st_a = 1'b1;
    step();
    st_a = 1'b0;
    chk("restart_state", 64'(s_a), 1);
    chk("restart_count", 64'(c_a), 0);
    chk("restart_mask", 64'(m_a), 0);
    chk("restart_done", 64'(dn_a), 0);
    step(4);
    step(49);
    chk("pre_limit_state", 64'(s_a), 2);
    chk("pre_limit_count", 64'(c_a), 49);
    step();
    chk("limit_state", 64'(s_a), 3);
    chk("limit_count", 64'(c_a), 50);
    chk("limit_timeout", 64'(to_a), 1);
    chk("limit_mask", 64'(m_a), 0);

    // 4: two harts halt at cycles 5 and 12
    go_b();
    step(4);
    h_b = 2'b01;
    step();
    h_b = 2'b00;
    chk("h0_mask", 64'(m_b), 1);
    chk("h0_state", 64'(s_b), 2);
    chk("h0_count", 64'(c_b), 5);
    step(6);
    h_b = 2'b10;
    step();
    h_b = 2'b00;
    chk("h1_state", 64'(s_b), 3);
    chk("h1_count", 64'(c_b), 12);
    chk("h1_mask", 64'(m_b), 3);
    chk("h1_timeout", 64'(to_b), 0);

    // 5: halt coincides with limit 20 -> halt wins
    go_b();
    step(19);
    h_b = 2'b11;
    step();
    h_b = 2'b00;
    chk("tie_state", 64'(s_b), 3);
    chk("tie_count", 64'(c_b), 20);
    chk("tie_timeout", 64'(to_b), 0);

    // abort (with start) at RUN cycle 7
    go_b();
    step(6);
    ab_b = 1'b1;
    st_b = 1'b1;
    step();
    ab_b = 1'b0;
    st_b = 1'b0;
    chk("abort_state", 64'(s_b), 0);
    chk("abort_core_reset", 64'(cr_b), 1);
    chk("abort_count", 64'(c_b), 7);
    step();
    chk("idle_hold_count", 64'(c_b), 7);

    // abort with start during RST_HOLD
    st_b = 1'b1;
    step();
    ab_b = 1'b1;
    step();
    ab_b = 1'b0;
    st_b = 1'b0;
    chk("abort_hold_state", 64'(s_b), 0);
    chk("abort_hold_count", 64'(c_b), 0);

    // saturating counter, timeout disabled, single-cycle reset hold
    st_c = 1'b1;
    step();
    st_c = 1'b0;
    chk("c_hold_state", 64'(s_c), 1);
    step();
    chk("c_run_state", 64'(s_c), 2);
    chk("c_run_core_reset", 64'(cr_c), 0);
    step(20);
    chk("sat_count", 64'(c_c), 15);
    chk("sat_state", 64'(s_c), 2);

    go_b();
`ifdef RUN_CTRL_INSTRET_EN
    // 6: both harts retire for 8 cycles, then a halted hart stops counting
    rt_b = 2'b11;
    step(8);
    rt_b = 2'b00;
    chk("instret_16", 64'(ic_b), 16);
    h_b = 2'b01;
    step();
    h_b = 2'b00;
    rt_b = 2'b11;
    step();
    rt_b = 2'b00;
    chk("instret_masked", 64'(ic_b), 17);
`else
    step(3);
`endif
    chk("pre_reset_state", 64'(s_b), 2);

    // reset mid-RUN
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mid_rst_state", 64'(s_b), 0);
    chk("mid_rst_core_reset", 64'(cr_b), 1);
    chk("mid_rst_mask", 64'(m_b), 0);
    chk("mid_rst_count", 64'(c_b), 0);
    chk("mid_rst_done", 64'(dn_b), 0);
    chk("mid_rst_timeout", 64'(to_b), 0);
    chk("mid_rst_c_count", 64'(c_c), 0);
`ifdef RUN_CTRL_INSTRET_EN
    chk("mid_rst_instret", 64'(ic_b), 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
